// File: rtl/m3_step_ramp_gen.sv
// m3_step_ramp_gen: commutation-step generator for the 3-phase drive.
// Steps an index over STEPS positions with a programmable dwell, applies
// frequency requests at step boundaries and power requests immediately.
// Optional soft stop (ramp down to PERIOD_MAX before idling): M3_SOFT_STOP_EN.
module m3_step_ramp_gen #(
    parameter int STEPS      = 12,
    parameter int PERIOD_W   = 22,
    parameter int PERIOD_MAX = 4000000,
    parameter int PERIOD_MIN = 40,
    parameter int RATE_SH    = 3,
    parameter int POWER_W    = 10,
    parameter int POWER_INIT = 102,
    parameter int POWER_STEP = 8
) (
    input  logic                       clkI,
    input  logic                       rstI,
    input  logic                       startI,
    input  logic                       forceStopI,
    input  logic                       invRotateI,
    input  logic                       freqIncI,
    input  logic                       freqDecI,
    input  logic                       powerIncI,
    input  logic                       powerDecI,
    output logic [$clog2(STEPS)-1:0]   stepO,
    output logic                       stepValidO,
    output logic                       stepStrobeO,
    output logic [PERIOD_W-1:0]        periodO,
    output logic [POWER_W-1:0]         powerO,
    output logic [1:0]                 stateO
);
    localparam int SW = $clog2(STEPS);
    localparam logic [PERIOD_W-1:0] PMAX   = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W:0]   PMAX_X = (PERIOD_W+1)'(PERIOD_MAX);
    localparam logic [PERIOD_W:0]   PMIN_X = (PERIOD_W+1)'(PERIOD_MIN);
    localparam logic [POWER_W:0]    PSTEP_X = (POWER_W+1)'(POWER_STEP);
    localparam logic [POWER_W:0]    PWMAX_X = {1'b0, {POWER_W{1'b1}}};
    localparam logic [SW-1:0]       LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_STOP = 2'b10} state_e;
    typedef enum logic [1:0] {P_NONE = 2'b00, P_INC = 2'b01, P_DEC = 2'b10} pend_e;

    state_e              state_q, state_d;
    pend_e               pend_q, pend_d, req, pend_eff;
    logic [SW-1:0]       step_q, step_d, step_next;
    logic                valid_q, valid_d, strobe_q, strobe_d;
    logic [PERIOD_W-1:0] period_q, period_d, remain_q, remain_d, new_p;
    logic [POWER_W-1:0]  power_q, power_d, power_next;
    logic [POWER_W:0]    pw_x, pw_up;
    logic                boundary, go_idle;

    // Period +/- max(period>>RATE_SH,1) at one extra bit, then clamp.
    function automatic logic [PERIOD_W-1:0] period_adj(input logic [PERIOD_W-1:0] p,
                                                       input logic slower);
        logic [PERIOD_W:0] px, delta, r;
        px    = {1'b0, p};
        delta = px >> RATE_SH;
        if (delta == '0) delta = (PERIOD_W+1)'(1);
        if (slower) begin
            r = px + delta;
            if (r > PMAX_X) r = PMAX_X;
        end else begin
            if (px < PMIN_X + delta) r = PMIN_X;
            else                     r = px - delta;
        end
        return PERIOD_W'(r);
    endfunction

    // Next step index in the currently requested direction, wrapping.
    always_comb begin
        step_next = step_q + SW'(1);
        if (invRotateI) step_next = (step_q == '0) ? LAST_STEP : step_q - SW'(1);
        else if (step_q == LAST_STEP) step_next = '0;
    end

    // Saturating power update; simultaneous up/down cancels.
    always_comb begin
        pw_x       = {1'b0, power_q};
        pw_up      = pw_x + PSTEP_X;
        power_next = power_q;
        if (powerIncI && !powerDecI)
            power_next = (pw_up > PWMAX_X) ? '1 : POWER_W'(pw_up);
        else if (powerDecI && !powerIncI)
            power_next = (pw_x < PSTEP_X) ? '0 : POWER_W'(pw_x - PSTEP_X);
    end

    // Next-state logic: start/stop sequencing, dwell countdown, boundary updates.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        period_d = period_q;
        power_d  = power_q;
        remain_d = remain_q;
        pend_d   = pend_q;
        go_idle  = 1'b0;
        new_p    = period_q;
        req      = P_NONE;
        if (freqIncI && !freqDecI)      req = P_INC;
        else if (freqDecI && !freqIncI) req = P_DEC;
        // A request in the boundary cycle itself is the latest one and wins.
        pend_eff = (req != P_NONE) ? req : pend_q;
        boundary = (remain_q == PERIOD_W'(1));
        case (state_q)
            S_IDLE: begin
                if (startI) begin
                    state_d  = S_RUN;
                    step_d   = invRotateI ? LAST_STEP : '0;
                    valid_d  = 1'b1;
                    strobe_d = 1'b1;
                    remain_d = period_q;
                end
            end
            S_RUN: begin
                power_d = power_next;
                if (boundary) begin
                    if (pend_eff != P_NONE) new_p = period_adj(period_q, pend_eff == P_DEC);
                    step_d   = step_next;
                    strobe_d = 1'b1;
                    period_d = new_p;
                    remain_d = new_p;
                    pend_d   = P_NONE;
                end else begin
                    remain_d = remain_q - PERIOD_W'(1);
                    pend_d   = pend_eff;
                end
                if (!startI) begin
`ifdef M3_SOFT_STOP_EN
                    state_d = S_STOP;
                    pend_d  = P_NONE;
`else
                    go_idle = 1'b1;
`endif
                end
            end
`ifdef M3_SOFT_STOP_EN
            S_STOP: begin
                power_d = power_next;
                pend_d  = P_NONE;
                state_d = startI ? S_RUN : S_STOP;
                if (boundary) begin
                    if (!startI && period_q == PMAX) begin
                        go_idle = 1'b1;
                    end else begin
                        if (!startI) new_p = period_adj(period_q, 1'b1);
                        step_d   = step_next;
                        strobe_d = 1'b1;
                        period_d = new_p;
                        remain_d = new_p;
                    end
                end else begin
                    remain_d = remain_q - PERIOD_W'(1);
                end
            end
`endif
            default: go_idle = 1'b1;
        endcase
        if (forceStopI || go_idle) begin
            state_d  = S_IDLE;
            step_d   = '1;
            valid_d  = 1'b0;
            strobe_d = 1'b0;
            period_d = PMAX;
            power_d  = POWER_W'(POWER_INIT);
            remain_d = PMAX;
            pend_d   = P_NONE;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q  <= S_IDLE;
            step_q   <= '1;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            period_q <= PMAX;
            power_q  <= POWER_W'(POWER_INIT);
            remain_q <= PMAX;
            pend_q   <= P_NONE;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            period_q <= period_d;
            power_q  <= power_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
        end
    end

    assign stepO       = step_q;
    assign stepValidO  = valid_q;
    assign stepStrobeO = strobe_q;
    assign periodO     = period_q;
    assign powerO      = power_q;
    assign stateO      = state_q;
endmodule

// File: tb/tb_m3_step_ramp_gen.sv
// Bench for m3_step_ramp_gen: directed scenarios plus random stimulus,
// every cycle checked against a behavioural model of the step generator.
module tb_m3_step_ramp_gen;
    localparam int S    = 12;
    localparam int SW   = $clog2(S);
    localparam int PW   = 22;
    localparam int PMAX = 400;
    localparam int PMIN = 40;
    localparam int PWW  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, fs = 1'b0, inv = 1'b0;
    logic fi = 1'b0, fd = 1'b0, pi = 1'b0, pd = 1'b0;
    logic [SW-1:0]  stepO;
    logic           validO, strobeO;
    logic [PW-1:0]  periodO;
    logic [PWW-1:0] powerO;
    logic [1:0]     stateO;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // Model: 0 idle, 1 run, 2 stop; pend: 0 none, -1 faster, +1 slower
    int m_state, m_step, m_valid, m_strobe, m_period, m_power, m_elapsed, m_pend;

    m3_step_ramp_gen #(.STEPS(S), .PERIOD_W(PW), .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN),
                       .RATE_SH(3), .POWER_W(PWW), .POWER_INIT(102), .POWER_STEP(8)) dut (
        .clkI(clk), .rstI(rst), .startI(start), .forceStopI(fs), .invRotateI(inv),
        .freqIncI(fi), .freqDecI(fd), .powerIncI(pi), .powerDecI(pd),
        .stepO(stepO), .stepValidO(validO), .stepStrobeO(strobeO),
        .periodO(periodO), .powerO(powerO), .stateO(stateO));

    always #5 clk = ~clk;

    function automatic int faster(input int p);
        int d = (p >> 3 < 1) ? 1 : p >> 3;
        return (p - d < PMIN) ? PMIN : p - d;
    endfunction
    function automatic int slower(input int p);
        int d = (p >> 3 < 1) ? 1 : p >> 3;
        return (p + d > PMAX) ? PMAX : p + d;
    endfunction

    task automatic m_idle();
        m_state = 0; m_step = (1 << SW) - 1; m_valid = 0; m_strobe = 0;
        m_period = PMAX; m_power = 102; m_elapsed = 0; m_pend = 0;
    endtask

    task automatic m_power_upd();
        if (pi && !pd) m_power = (m_power + 8 > 1023) ? 1023 : m_power + 8;
        else if (pd && !pi) m_power = (m_power < 8) ? 0 : m_power - 8;
    endtask

    task automatic m_advance();
        m_step = inv ? (m_step + S - 1) % S : (m_step + 1) % S;
        m_strobe = 1; m_elapsed = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs held this cycle.
    task automatic model_step();
        m_strobe = 0;
        if (rst || fs) begin
            m_idle();
        end else if (m_state == 0) begin
            if (start) begin
                m_state = 1; m_valid = 1; m_strobe = 1; m_elapsed = 0;
                m_step = inv ? S - 1 : 0;
            end
        end else if (m_state == 1) begin
            if (fi && !fd) m_pend = -1;
            else if (fd && !fi) m_pend = 1;
            m_power_upd();
            m_elapsed++;
            if (m_elapsed == m_period) begin
                if (m_pend < 0) m_period = faster(m_period);
                else if (m_pend > 0) m_period = slower(m_period);
                m_pend = 0;
                m_advance();
            end
            if (!start) begin
`ifdef M3_SOFT_STOP_EN
                m_state = 2; m_pend = 0;
`else
                m_idle();
`endif
            end
        end else begin
            m_pend = 0;
            m_power_upd();
            m_elapsed++;
            if (m_elapsed == m_period) begin
                if (!start && m_period == PMAX) m_idle();
                else begin
                    if (!start) m_period = slower(m_period);
                    m_advance();
                end
            end
            if (m_state != 0) m_state = start ? 1 : 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        fi = 1'b0; fd = 1'b0; pi = 1'b0; pd = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick();
            seen = strobeO;
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no step strobe within 1000 cycles, got 0 expected 1", name);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (stateO !== 2'(m_state) || stepO !== SW'(m_step) || validO !== 1'(m_valid) ||
                strobeO !== 1'(m_strobe) || periodO !== PW'(m_period) || powerO !== PWW'(m_power)) begin
                n_fail++;
                $display("FAIL model cyc %0d: got st=%0d step=%0d v=%0d strb=%0d per=%0d pow=%0d expected st=%0d step=%0d v=%0d strb=%0d per=%0d pow=%0d",
                         cyc, stateO, stepO, validO, strobeO, periodO, powerO,
                         m_state, m_step, m_valid, m_strobe, m_period, m_power);
            end
        end
    end

    initial begin
        m_idle();
        #1;
        ticks(2);
        chk_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("reset step", int'(stepO), 15);
        chk("reset valid", int'(validO), 0);
        chk("reset period", int'(periodO), 400);
        chk("reset power", int'(powerO), 102);
        chk("reset state", int'(stateO), 0);

        // Forward stepping and wrap
        start = 1'b1;
        tick();
        chk("start step", int'(stepO), 0);
        chk("start strobe", int'(strobeO), 1);
        for (int k = 1; k <= 12; k++) begin
            wait_strobe("fwd strobe");
            if (k == 11) chk("step 11", int'(stepO), 11);
        end
        chk("wrap to 0", int'(stepO), 0);

        // Three faster requests in one dwell apply once
        fi = 1'b1; tick(); tick();
        fi = 1'b1; tick(); tick();
        fi = 1'b1; tick();
        wait_strobe("inc strobe");
        chk("period 350", int'(periodO), 350);
        for (int k = 0; k < 40; k++) begin
            fi = 1'b1; tick();
            wait_strobe("inc sat strobe");
        end
        chk("period floor", int'(periodO), 40);
        fd = 1'b1; tick();
        wait_strobe("dec strobe");
        chk("period 45", int'(periodO), 45);
        fi = 1'b1; fd = 1'b1; tick();
        wait_strobe("both strobe");
        chk("inc+dec no change", int'(periodO), 45);

        // Power saturation
        pi = 1'b1; tick();
        chk("power 110", int'(powerO), 110);
        pi = 1'b1; tick();
        chk("power 118", int'(powerO), 118);
        for (int k = 0; k < 130; k++) begin pi = 1'b1; tick(); end
        chk("power ceil", int'(powerO), 1023);
        for (int k = 0; k < 130; k++) begin pd = 1'b1; tick(); end
        chk("power floor", int'(powerO), 0);

        // Force stop and mid-run reset
        fs = 1'b1; tick(); fs = 1'b0;
        chk("fstop state", int'(stateO), 0);
        chk("fstop step", int'(stepO), 15);
        chk("fstop power", int'(powerO), 102);
        chk("fstop period", int'(periodO), 400);
        ticks(30);
        pi = 1'b1; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst state", int'(stateO), 0);
        chk("rst step", int'(stepO), 15);
        chk("rst power", int'(powerO), 102);
        start = 1'b0; tick();

        // Reverse direction, mid-dwell toggle
        inv = 1'b1; start = 1'b1; tick();
        chk("rev start", int'(stepO), 11);
        wait_strobe("rev strobe");
        chk("rev 10", int'(stepO), 10);
        ticks(100); inv = 1'b0; ticks(50);
        chk("toggle held", int'(stepO), 10);
        wait_strobe("toggle strobe");
        chk("toggle fwd", int'(stepO), 11);

        // Dropping start
        ticks(20);
        start = 1'b0; tick();
`ifdef M3_SOFT_STOP_EN
        chk("soft stop state", int'(stateO), 2);
`else
        chk("stop state", int'(stateO), 0);
`endif

        // Randomised traffic
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(0, 399) == 0) start = ~start;
            if ($urandom_range(0, 299) == 0) inv = ~inv;
            rst = ($urandom_range(0, 2999) == 0);
            fs  = ($urandom_range(0, 1999) == 0);
            fi  = ($urandom_range(0, 39) == 0);
            fd  = ($urandom_range(0, 49) == 0);
            pi  = ($urandom_range(0, 14) == 0);
            pd  = ($urandom_range(0, 14) == 0);
            tick();
            rst = 1'b0; fs = 1'b0;
        end

        ticks(3);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/m3_step_ramp_gen.md
Name: m3_step_ramp_gen

Overview:
Parametrised commutation-step generator for the 3-phase motor drive, successor to the fixed 12-step power/speed calculator.
- Produces a step index that wraps over STEPS positions, with a programmable dwell period per step.
- Acts on direction, frequency up/down and power up/down requests, with saturation and a defined start/stop sequence.
- Sits between the button/command decoder and the PWM/sine-table stage.

Parameters:
STEPS, 12, commutation steps per electrical cycle (2..16)
PERIOD_W, 22, width of period/dwell counters
PERIOD_MAX, 4000000, slowest dwell in clkI cycles; also the start period
PERIOD_MIN, 40, fastest dwell in clkI cycles
RATE_SH, 3, period change per frequency request is period>>RATE_SH, minimum 1
POWER_W, 10, power word width
POWER_INIT, 102, power value while idle and at start
POWER_STEP, 8, power change per request

Ports:
clkI  in  1  clock, 1 MHz nominal
rstI  in  1  reset, synchronous active-high
startI  in  1  level; 1 = run
forceStopI  in  1  level; 1 = immediate stop, overrides everything except reset
invRotateI  in  1  level; 1 = reverse step order
freqIncI  in  1  single-cycle pulse; request faster (shorter period)
freqDecI  in  1  single-cycle pulse; request slower
powerIncI  in  1  single-cycle pulse; power up
powerDecI  in  1  single-cycle pulse; power down
stepO  out  SW=$clog2(STEPS)  current step index
stepValidO  out  1  stepO is meaningful
stepStrobeO  out  1  one-cycle pulse on every step change
periodO  out  PERIOD_W  current dwell period
powerO  out  POWER_W  current power word
stateO  out  2  00 IDLE, 01 RUN, 10 STOP

Behaviour:
Reset:
- Synchronous to clkI: IDLE, stepO=all ones, stepValidO=0, stepStrobeO=0, periodO=PERIOD_MAX, powerO=POWER_INIT, remain=PERIOD_MAX, pending requests cleared.
- Asserting rstI mid-run returns everything to these values on the next edge.

forceStopI=1: go to IDLE on the next edge with the reset values, in any state.

IDLE:
- Outputs held at their reset values.
- Frequency and power requests are ignored.
- startI=1 and forceStopI=0 -> RUN. On that edge:
  - stepO = 0 if invRotateI=0, else STEPS-1
  - stepValidO=1, stepStrobeO=1 for one cycle
  - remain=periodO

RUN:
- remain decrements by 1 each cycle.
- When remain==1, on the next edge:
  - stepO advances: +1 with STEPS-1 -> 0 wrap, or -1 with 0 -> STEPS-1 wrap when invRotateI=1. Direction is sampled only at this edge.
  - stepStrobeO=1.
  - periodO takes any pending frequency change.
  - remain reloads with the new periodO.
- Result: the dwell of each step is exactly periodO cycles.

Frequency requests:
- A freqIncI or freqDecI pulse sets a single pending flag. A later request overwrites an earlier one.
- freqIncI and freqDecI in the same cycle: both ignored.
- Applied only at a step boundary:
  - Inc: period - max(period>>RATE_SH,1), clamped at PERIOD_MIN.
  - Dec: period + max(period>>RATE_SH,1), clamped at PERIOD_MAX.
- Arithmetic is done at PERIOD_W+1 bits before clamping; no wrap is allowed.

Power requests:
- Applied the next cycle while RUN or STOP.
- Saturating: at most 2^POWER_W-1, at least 0.
- powerIncI and powerDecI together: no change.

startI=0 in RUN:
- Goes to IDLE, or to STOP when the optional feature is enabled (see below).

Optional Feature:
Macro: M3_SOFT_STOP_EN

Defined:
- startI falling in RUN -> STOP.
- STOP keeps stepping exactly as RUN, but forces a slow-down (Dec) at every step boundary.
- Pending requests are ignored in STOP.
- When a boundary is reached with periodO==PERIOD_MAX -> IDLE.
- startI=1 in STOP -> RUN without resetting step or period.

Undefined:
- startI=0 in RUN -> IDLE on the next edge.
- The STOP encoding is never produced.

Test Plan:
1. Simulation with PERIOD_MAX=400, STEPS=12: reset, startI=1 -> stepO 0 on the first edge, then stepStrobeO every 400 cycles through 0..11, wrapping to 0 at the 13th strobe.
2. invRotateI=1 before start -> sequence 11,10,..,0,11. Toggle invRotateI mid-dwell -> direction changes only at the next strobe.
3. Period=400 with 3 freqIncI pulses in one dwell -> next period 350. Repeated incs saturate at 40 and never go below. Inc+dec in the same cycle -> period unchanged.
4. powerIncI pulses from 102 -> 110, 118, ... saturating at 1023. powerDecI from 4 -> 0 and stays 0.
5. forceStopI mid-run with startI=1 -> next edge IDLE, stepO=all ones, powerO=102, periodO=400. rstI mid-run gives the same result.
6. M3_SOFT_STOP_EN with period=40, startI dropped -> periods 45, 50, 56, ... up to 400, then IDLE. Without the macro -> IDLE on the next edge.
